// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and FSM state type for the time-multiplexed FIR MAC.
package fir_pkg;

  localparam int unsigned N_TAPS   = 8;
  localparam int unsigned DW       = 8;
  localparam int unsigned AW       = 2 * DW + $clog2(N_TAPS);
  localparam int unsigned MAX_TAPS = 16;

  typedef logic signed [DW-1:0] coef_t;
  typedef coef_t coef_arr_t [MAX_TAPS];

  // h[k] = k+1; the first N_TAPS entries are the active coefficient set
  localparam coef_arr_t H_DEFAULT = '{
    8'sd1,  8'sd2,  8'sd3,  8'sd4,  8'sd5,  8'sd6,  8'sd7,  8'sd8,
    8'sd9,  8'sd10, 8'sd11, 8'sd12, 8'sd13, 8'sd14, 8'sd15, 8'sd16
  };

  typedef enum logic {
    IDLE,
    MAC
  } state_t;

endpackage

// File: rtl/fir_mac_core_if.sv
// Sample-in / result-out signal bundle between the register stage and the FIR MAC core.
interface fir_mac_core_if #(
  parameter int unsigned DW = fir_pkg::DW,
  parameter int unsigned AW = fir_pkg::AW
);

  logic                 valid_in;
  logic signed [DW-1:0] x_in;
  logic                 ovr_clr;
  logic signed [AW-1:0] y_out;
  logic                 valid_out;
  logic                 busy;
  logic                 overrun;

  modport master (
    output valid_in, x_in, ovr_clr,
    input  y_out, valid_out, busy, overrun
  );

  modport slave (
    input  valid_in, x_in, ovr_clr,
    output y_out, valid_out, busy, overrun
  );

endinterface

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup h[idx] from the package constant table.
module fir_coef_rom
  import fir_pkg::H_DEFAULT;
#(
  parameter int unsigned N_TAPS = fir_pkg::N_TAPS,
  parameter int unsigned DW     = fir_pkg::DW
) (
  input  logic [$clog2(N_TAPS)-1:0] idx,
  output logic signed [DW-1:0]      coef
);

  always_comb begin
    coef = DW'(H_DEFAULT[idx]);
  end

endmodule

// File: rtl/fir_mac_core.sv
// FIR filter with one multiplier and one accumulator, stepping through N_TAPS taps per sample.
module fir_mac_core
  import fir_pkg::state_t;
  import fir_pkg::IDLE;
  import fir_pkg::MAC;
#(
  parameter int unsigned N_TAPS = fir_pkg::N_TAPS,
  parameter int unsigned DW     = fir_pkg::DW,
  parameter int unsigned AW     = fir_pkg::AW
) (
  input  logic            ACLK,
  input  logic            ARESET,
  fir_mac_core_if.slave   bus
);

  localparam int unsigned CW = $clog2(N_TAPS);
  localparam int unsigned PW = 2 * DW;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] slot [N_TAPS];
  logic signed [DW-1:0] coef;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] acc_next;

  fir_coef_rom #(
    .N_TAPS (N_TAPS),
    .DW     (DW)
  ) u_coef_rom (
    .idx  (cnt),
    .coef (coef)
  );

  always_comb begin
    prod     = coef * slot[cnt];
    prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
    acc_next = acc + prod_ext;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      for (int unsigned i = 0; i < N_TAPS; i++) begin
        slot[i] <= '0;
      end
      bus.y_out     <= '0;
      bus.valid_out <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.valid_out <= 1'b0;
      if (bus.ovr_clr) begin
        bus.overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            slot[0] <= bus.x_in;
            for (int unsigned i = N_TAPS - 1; i > 0; i--) begin
              slot[i] <= slot[i-1];
            end
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          // A sample arriving mid-sequence is dropped; this set overrides ovr_clr above
          if (bus.valid_in) begin
            bus.overrun <= 1'b1;
          end
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N_TAPS - 1)) begin
            bus.y_out     <= acc_next;
            bus.valid_out <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_core.sv
// Self-checking bench: behavioural FIR model compared every cycle, plus directed literal cases.
module tb_fir_mac_core;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 19;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b0;

  always #5 ACLK = ~ACLK;

  fir_mac_core_if #(.DW(DW), .AW(AW)) bus ();

  fir_mac_core #(
    .N_TAPS (N),
    .DW     (DW),
    .AW     (AW)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural model: history of accepted samples, result due N edges after acceptance
  int hist [N];
  int m_left = 0;
  int m_pend = 0;
  int m_y    = 0;
  bit m_vout = 1'b0;
  bit m_busy = 1'b0;
  bit m_ovr  = 1'b0;
  int vout_count = 0;

  initial begin
    for (int k = 0; k < N; k++) hist[k] = 0;
  end

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < N; k++) hist[k] = 0;
      m_left = 0;
      m_pend = 0;
      m_y    = 0;
      m_vout = 1'b0;
      m_busy = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      m_vout = 1'b0;
      if (bus.ovr_clr) m_ovr = 1'b0;
      if (m_left == 0) begin
        if (bus.valid_in) begin
          for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = int'(bus.x_in);
          m_pend = 0;
          for (int k = 0; k < N; k++) m_pend += (k + 1) * hist[k];
          m_left = N;
          m_busy = 1'b1;
        end
      end else begin
        if (bus.valid_in) m_ovr = 1'b1;
        m_left--;
        if (m_left == 0) begin
          m_y    = m_pend;
          m_vout = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (!ARESET) begin
      check("y_out",     int'(bus.y_out),     m_y);
      check("valid_out", int'(bus.valid_out), int'(m_vout));
      check("busy",      int'(bus.busy),      int'(m_busy));
      check("overrun",   int'(bus.overrun),   int'(m_ovr));
      if (bus.valid_out) vout_count++;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    #2;
    ARESET = 1'b0;
  endtask

  task automatic send(input int x);
    bus.x_in     = DW'(x);
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic get(output int y, output int edges, output int busy_cyc);
    bit got = 1'b0;
    y = 0;
    edges = 0;
    busy_cyc = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (bus.busy) busy_cyc++;
      tick();
      edges++;
      if (bus.valid_out) begin
        y   = int'(bus.y_out);
        got = 1'b1;
      end
    end
    if (!got) check("result_timeout", int'(got), 1);
  endtask

  int y, e, b, vc0;

  initial begin
    bus.valid_in = 1'b0;
    bus.x_in     = '0;
    bus.ovr_clr  = 1'b0;
    #1 ARESET = 1'b1;
    #11 ARESET = 1'b0;
    tick();

    check("rst_y_out",     int'(bus.y_out), 0);
    check("rst_valid_out", int'(bus.valid_out), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_overrun",   int'(bus.overrun), 0);

    // Impulse response walks out the coefficients, then flushes to zero
    for (int i = 0; i < 9; i++) begin
      send(i == 0 ? 1 : 0);
      get(y, e, b);
      check($sformatf("impulse_%0d", i), y, (i < 8) ? i + 1 : 0);
    end

    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(1);
      get(y, e, b);
      check($sformatf("step_%0d", i), y, (i + 1) * (i + 2) / 2);
    end
    check("step_overrun", int'(bus.overrun), 0);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(-128);
      get(y, e, b);
    end
    check("extreme_neg", y, -4608);
    check("extreme_neg_hex", int'($unsigned(bus.y_out)), 'h7EE00);
    for (int i = 0; i < 8; i++) begin
      send(127);
      get(y, e, b);
    end
    check("extreme_pos", y, 4572);

    do_reset();
    vc0 = vout_count;
    send(5);
    tick();
    tick();
    send(9);
    get(y, e, b);
    check("ovr_result", y, 5);
    repeat (15) tick();
    check("ovr_single_valid", vout_count - vc0, 1);
    check("ovr_sticky", int'(bus.overrun), 1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check("ovr_cleared", int'(bus.overrun), 0);

    send(3);
    bus.valid_in = 1'b1;
    bus.ovr_clr  = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.ovr_clr  = 1'b0;
    check("ovr_set_wins", int'(bus.overrun), 1);
    get(y, e, b);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;

    do_reset();
    send(7);
    repeat (4) tick();
    do_reset();
    vc0 = vout_count;
    repeat (15) tick();
    check("abort_no_valid", vout_count - vc0, 0);
    check("abort_y_zero", int'(bus.y_out), 0);
    send(2);
    get(y, e, b);
    check("abort_fresh_history", y, 2);

    send(4);
    get(y, e, b);
    check("latency_edges", e, 8);
    check("busy_cycles", b, 8);
    check("latency_result", y, 8);

    do_reset();
    repeat (3000) begin
      bus.valid_in = ($urandom_range(0, 2) == 0);
      bus.x_in     = DW'($urandom);
      bus.ovr_clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end
    bus.valid_in = 1'b0;
    bus.ovr_clr  = 1'b0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_mac_core.md
FIR_MAC_CORE -- requirements
Module: fir_mac_core

Interface
REQ-001 SHALL have parameter N_TAPS, default 8, number of filter taps (power of two, 2..16).
REQ-002 SHALL have parameter DW, default 8, sample and coefficient width, signed two's complement.
REQ-003 SHALL have parameter AW, default 19, output width, equal to 2*DW+log2(N_TAPS).
REQ-004 ACLK  in  1  single clock; every register updates on its rising edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 valid_in  in  1  one-cycle strobe from the AXI4-Lite register stage when it writes a new sample.
REQ-007 x_in  in  DW  new sample, signed; sampled only when valid_in=1.
REQ-008 ovr_clr  in  1  clears the overrun flag.
REQ-009 y_out  out  AW  last filter result, signed; held until the next result.
REQ-010 valid_out  out  1  one-cycle strobe marking a new y_out.
REQ-011 busy  out  1  MAC sequence in progress.
REQ-012 overrun  out  1  sticky; set when a sample is dropped.

Function
REQ-013 Computes y[n] = sum over k=0..N_TAPS-1 of h[k]*x[n-k], using one multiplier and one accumulator, time-multiplexed.
REQ-014 Coefficients h[k] SHALL be constants; the default set is h = 1,2,3,4,5,6,7,8 for k=0..7.
REQ-015 States: IDLE, MAC.
REQ-016 IDLE with valid_in=1: x_in shifts into delay-line slot 0 (older samples move up one slot, the oldest is discarded); acc<=0; tap counter<=0; busy<=1; go to MAC.
REQ-017 MAC: each cycle acc<=acc+h[cnt]*slot[cnt] at full signed precision; cnt increments.
REQ-018 MAC at cnt=N_TAPS-1: y_out<=acc+final product; valid_out<=1 for exactly one cycle; busy<=0; go to IDLE.
REQ-019 Latency: valid_out is high in the cycle after the N_TAPS-th rising edge following the accepting edge (8 edges at default).
REQ-020 Throughput: the block SHALL accept a new valid_in in the same cycle valid_out is high, giving one sample every N_TAPS+1 cycles.
REQ-021 valid_in while busy=1: the sample is dropped, the delay line is unchanged, and overrun<=1.
REQ-022 ovr_clr=1 clears overrun; if ovr_clr and a drop coincide, overrun SHALL be 1 (set wins).
REQ-023 Products are sign-extended to AW before accumulation; overflow is impossible by width choice, and no saturation is applied.
REQ-024 y_out SHALL NOT change except at the REQ-018 edge.

Reset
REQ-025 ARESET=1 SHALL asynchronously force: state=IDLE, cnt=0, acc=0, all delay-line slots=0, y_out=0, valid_out=0, busy=0, overrun=0.
REQ-026 Reset during MAC SHALL abort the sequence with no valid_out; the first sample after release SHALL be computed against an all-zero history.
REQ-027 A valid_in coincident with ARESET SHALL be ignored.

Structure
REQ-028 The package fir_pkg SHALL hold N_TAPS, DW, AW, the coefficient array type, and the default coefficient constants, plus the state enum type.
REQ-029 The sub-module fir_coef_rom SHALL provide a combinational h[cnt] lookup from the package constants; the delay line, FSM, and MAC SHALL live in fir_mac_core.

Verification
REQ-030 Impulse: x=1, then seven samples of 0, spaced 9 cycles apart -> y_out = 1,2,3,4,5,6,7,8; the next 0 -> 0.
REQ-031 Step: eight samples of x=1 back-to-back at the maximum rate -> y_out = 1,3,6,10,15,21,28,36; overrun stays 0.
REQ-032 Extreme: eight samples of x=-128 -> final y_out = -4608 (0x7EE00 at 19 bits); x=127 repeated -> 4572.
REQ-033 Overrun: a second valid_in 3 cycles after the first (x=5, then x=9) -> only one valid_out, with y_out=5; overrun=1; it stays 1 until ovr_clr, then 0.
REQ-034 Reset mid-MAC: x=7 accepted, ARESET pulsed at cnt=4 -> no valid_out, y_out=0; then x=2 -> y_out=2.
REQ-035 Latency: count edges from the accepting edge to valid_out -> exactly 8 at default; busy is high for exactly 8 cycles.
